// File: rtl/psum_relu_quant_pack_if.sv
// Stream-in / SRAM-write bundle for the psum requantize-and-pack block.
// master: the packer (consumes psums, drives SRAM writes).
// slave:  the surrounding system (drives psums and SRAM ready).
interface psum_relu_quant_pack_if #(
    parameter int ADDR_W = 10
);
    logic signed [20:0]  data_in;
    logic                data_in_valid;
    logic                sram_ready;
    logic                sram_we;
    logic [ADDR_W-1:0]   sram_waddr;
    logic [31:0]         sram_wdata;

    modport master (
        input  data_in, data_in_valid, sram_ready,
        output sram_we, sram_waddr, sram_wdata
    );

    modport slave (
        output data_in, data_in_valid, sram_ready,
        input  sram_we, sram_waddr, sram_wdata
    );
endinterface

// File: rtl/psum_relu_quant_pack.sv
// ReLU + round-half-up requantization of 21-bit psums to bytes, packs
// BATCHES bytes per word and writes words to SRAM through a 2-deep FIFO.
//
// state | meaning
// IDLE  | waiting for a rising edge on en
// RUN   | accepting psums, writing packed words
// FLUSH | en dropped: push any partial word, drain FIFO
// DONE  | one-cycle layer_done pulse, then back to IDLE
module psum_relu_quant_pack #(
    parameter int BATCHES   = 4,
    parameter int SHIFT     = 7,
    parameter int ADDR_W    = 10,
    parameter int NUM_WORDS = 196
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    psum_relu_quant_pack_if.master bus,
    output logic                  layer_done,
    output logic                  overflow
);
    localparam int                LANE_W    = $clog2(BATCHES);
    localparam int                WORD_W    = 8 * BATCHES;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BATCHES - 1);
    localparam logic [21:0]       ROUND     = 22'(1) << (SHIFT - 1);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(NUM_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_en_q;
    logic [LANE_W-1:0]   r_lane;
    logic [WORD_W-1:0]   r_word;
    logic                r_word_rdy;
    logic [WORD_W-1:0]   r_fifo [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_fifo_cnt;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W:0]     r_wcnt;
    logic                r_overflow;

    logic                w_start;
    logic                w_active;
    logic                w_in_acc;
    logic                w_pop;
    logic                w_last;
    logic                w_flush_part;
    logic                w_push;
    logic                w_full;
    logic                w_push_ok;
    logic [21:0]         w_sum;
    logic [21:0]         w_shr;
    logic [7:0]          w_qbyte;
    logic [WORD_W-1:0]   w_word_nxt;

    assign w_start      = (r_state == S_IDLE) && en && !r_en_q;
    assign w_active     = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign w_in_acc     = (r_state == S_RUN) && bus.data_in_valid;
    assign w_pop        = w_active && (r_fifo_cnt != 2'd0) && bus.sram_ready;
    assign w_last       = w_pop && (r_wcnt == LAST_CNT);
    assign w_flush_part = (r_state == S_FLUSH) && (r_lane != '0);
    assign w_push       = w_active && (r_word_rdy || w_flush_part);
    assign w_full       = (r_fifo_cnt == 2'd2);
    assign w_push_ok    = w_push && (!w_full || w_pop);

    assign bus.sram_we    = w_active && (r_fifo_cnt != 2'd0);
    assign bus.sram_waddr = r_waddr;
    assign bus.sram_wdata = r_fifo[r_rd_ptr];
    assign overflow       = r_overflow;

    // ReLU, round half up, shift, saturate to a byte
    always_comb begin
        w_sum = {1'b0, bus.data_in} + ROUND;
        w_shr = w_sum >> SHIFT;
        if (bus.data_in[20]) begin
            w_qbyte = 8'd0;
        end else if (|w_shr[21:8]) begin
            w_qbyte = 8'hFF;
        end else begin
            w_qbyte = w_shr[7:0];
        end
    end

    // Drop the new byte into its lane; lane 0 starts a fresh zeroed word
    always_comb begin
        w_word_nxt = r_word;
        if (r_lane == '0) begin
            w_word_nxt = '0;
        end
        for (int k = 0; k < BATCHES; k++) begin
            if (r_lane == LANE_W'(k)) begin
                w_word_nxt[8*k +: 8] = w_qbyte;
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and layer_done decode
    always_comb begin
        w_state_nxt = r_state;
        layer_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_last)   w_state_nxt = S_DONE;
                else if (!en) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else if ((r_fifo_cnt == 2'd0) && !r_word_rdy && (r_lane == '0)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                layer_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // en history; reset to 1 so an en held high through reset cannot start a layer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_en_q <= 1'b1;
        end else begin
            r_en_q <= en;
        end
    end

    // Byte assembly: lane counter, word register and word-complete flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lane     <= '0;
            r_word     <= '0;
            r_word_rdy <= 1'b0;
        end else if (w_start) begin
            r_lane     <= '0;
            r_word     <= '0;
            r_word_rdy <= 1'b0;
        end else if (w_in_acc) begin
            r_word     <= w_word_nxt;
            r_lane     <= r_lane + LANE_W'(1);
            r_word_rdy <= (r_lane == LANE_LAST);
        end else begin
            r_word_rdy <= 1'b0;
            if (w_flush_part) r_lane <= '0;
        end
    end

    // Two-entry FIFO; a push into a full FIFO lands only if the head pops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_fifo[r_wr_ptr] <= r_word;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            if (w_push_ok && !w_pop) r_fifo_cnt <= r_fifo_cnt + 2'd1;
            else if (!w_push_ok && w_pop) r_fifo_cnt <= r_fifo_cnt - 2'd1;
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    // Write address and accepted-word count; address holds on the final write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_waddr <= '0;
            r_wcnt  <= '0;
        end else if (w_start) begin
            r_waddr <= '0;
            r_wcnt  <= '0;
        end else if (w_pop) begin
            r_wcnt <= r_wcnt + (ADDR_W + 1)'(1);
            if (!w_last) r_waddr <= r_waddr + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_psum_relu_quant_pack.sv
// Bench for psum_relu_quant_pack: directed scenarios plus randomized layers,
// expected SRAM writes queued by a byte-level reference model and popped by
// an independent monitor on every accepted write.
module tb_psum_relu_quant_pack;
    localparam int ADDR_W    = 10;
    localparam int NUM_WORDS = 2;
    localparam int SHIFT     = 7;

    typedef logic [ADDR_W+31:0] exp_t;

    logic clock = 1'b0;
    logic reset_n;
    logic en;
    logic layer_done;
    logic overflow;

    psum_relu_quant_pack_if #(.ADDR_W(ADDR_W)) bus ();

    psum_relu_quant_pack #(
        .BATCHES  (4),
        .SHIFT    (SHIFT),
        .ADDR_W   (ADDR_W),
        .NUM_WORDS(NUM_WORDS)
    ) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .bus       (bus),
        .layer_done(layer_done),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ld_cnt = 0;
    int   ready_mode = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] qref(input int v);
        int q;
        if (v < 0) return 8'd0;
        q = (v + 2 ** (SHIFT - 1)) / (2 ** SHIFT);
        if (q > 255) q = 255;
        return 8'(q);
    endfunction

    // Writes a layer of n accepted psums must produce: ceil(n/4) words, capped
    // at NUM_WORDS, missing upper bytes zero.
    task automatic expect_layer(input int vals[$]);
        int n, nw;
        logic [31:0] w;
        n  = vals.size();
        nw = (n + 3) / 4;
        if (nw > NUM_WORDS) nw = NUM_WORDS;
        for (int wi = 0; wi < nw; wi++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (4 * wi + k < n) w = w | (32'(qref(vals[4*wi+k])) << (8 * k));
            end
            exp_q.push_back({ADDR_W'(wi), w});
        end
    endtask

    // Monitor: every accepted write must match the head of the expected queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1) begin
                if (layer_done) ld_cnt++;
                if (bus.sram_we && bus.sram_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected",
                                 bus.sram_waddr, bus.sram_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", 64'(bus.sram_waddr), 64'(e[ADDR_W+31:32]));
                        check("write_data", 64'(bus.sram_wdata), 64'(e[31:0]));
                    end
                end
            end
        end
    end

    // SRAM ready driver; random mode never holds ready low two cycles running
    initial begin
        logic prev;
        prev = 1'b1;
        bus.sram_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       bus.sram_ready = 1'b1;
                1:       bus.sram_ready = 1'b0;
                default: bus.sram_ready = prev ? 1'($urandom % 2) : 1'b1;
            endcase
            prev = bus.sram_ready;
        end
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int v);
        bus.data_in       = 21'(v);
        bus.data_in_valid = 1'b1;
        tick();
        bus.data_in_valid = 1'b0;
    endtask

    task automatic start_layer();
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int ld0, input string tag);
        int t;
        t = 0;
        while (ld_cnt == ld0 && t < 300) begin
            @(negedge clock);
            t++;
        end
        repeat (4) tick();
        check({tag, "_done_pulses"}, 64'(ld_cnt - ld0), 64'd1);
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_word(input int v0, input int v1, input int v2, input int v3,
                            input logic [31:0] kword, input string tag);
        int vals[$];
        int ld0;
        vals = '{v0, v1, v2, v3};
        ld0  = ld_cnt;
        start_layer();
        expect_layer(vals);
        foreach (vals[i]) send(vals[i]);
        @(negedge clock);
        check({tag, "_we_plus1"}, 64'(bus.sram_we), 64'd0);
        @(negedge clock);
        check({tag, "_we_plus2"}, 64'(bus.sram_we), 64'd1);
        check({tag, "_word"}, 64'(bus.sram_wdata), 64'(kword));
        check({tag, "_addr"}, 64'(bus.sram_waddr), 64'd0);
        tick();
        en = 1'b0;
        wait_done(ld0, tag);
    endtask

    function automatic int rand_val();
        case ($urandom % 5)
            0:       return -int'($urandom_range(1, 1 << 20));
            1:       return int'($urandom_range(0, 400));
            2:       return int'($urandom_range(0, 300)) * 128 + 63 + int'($urandom % 2);
            3:       return int'($urandom_range(0, (1 << 20) - 1));
            default: return 32700 + int'($urandom % 200);
        endcase
    endfunction

    initial begin
        int vals[$];
        int ld0;
        int n;

        reset_n           = 1'b0;
        en                = 1'b0;
        bus.data_in       = '0;
        bus.data_in_valid = 1'b0;
        repeat (3) tick();
        check("rst_we", 64'(bus.sram_we), 64'd0);
        check("rst_waddr", 64'(bus.sram_waddr), 64'd0);
        check("rst_wdata", 64'(bus.sram_wdata), 64'd0);
        check("rst_layer_done", 64'(layer_done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        tick();

        // Mixed ReLU / saturation word and the rounding boundary
        run_word(1000, -500, 40000, 192, 32'h02FF0008, "mixed");
        run_word(63, 64, 191, -1, 32'h00010100, "round");

        // Backpressure: 12 inputs with SRAM stalled, third word dropped
        ready_mode = 1;
        repeat (2) tick();
        ld0 = ld_cnt;
        start_layer();
        vals.delete();
        for (int i = 0; i < 12; i++) vals.push_back(int'($urandom_range(100, 30000)));
        expect_layer(vals);
        foreach (vals[i]) send(vals[i]);
        repeat (3) tick();
        check("bp_overflow", 64'(overflow), 64'd1);
        check("bp_we_held", 64'(bus.sram_we), 64'd1);
        ready_mode = 0;
        wait_done(ld0, "bp");
        en = 1'b0;
        check("bp_overflow_sticky", 64'(overflow), 64'd1);

        // Layer end by word count, extra inputs ignored, then idle
        ld0 = ld_cnt;
        start_layer();
        check("overflow_cleared", 64'(overflow), 64'd0);
        vals.delete();
        for (int i = 0; i < 12; i++) vals.push_back(rand_val());
        expect_layer(vals);
        foreach (vals[i]) send(vals[i]);
        wait_done(ld0, "count_end");
        en = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_val());
        repeat (6) tick();
        check("idle_we", 64'(bus.sram_we), 64'd0);

        // Early stop after 6 inputs: second word zero-padded
        ld0 = ld_cnt;
        start_layer();
        vals.delete();
        for (int i = 0; i < 6; i++) vals.push_back(int'($urandom_range(200, 30000)));
        expect_layer(vals);
        foreach (vals[i]) send(vals[i]);
        en = 1'b0;
        wait_done(ld0, "early_stop");

        // Reset mid-layer with a full FIFO, overflow set and a partial word
        ready_mode = 1;
        repeat (2) tick();
        start_layer();
        for (int i = 0; i < 14; i++) send(int'($urandom_range(1000, 30000)));
        repeat (2) tick();
        check("rst_pre_we", 64'(bus.sram_we), 64'd1);
        check("rst_pre_overflow", 64'(overflow), 64'd1);
        #2;
        reset_n = 1'b0;
        en      = 1'b0;
        #1;
        check("async_rst_we", 64'(bus.sram_we), 64'd0);
        check("async_rst_waddr", 64'(bus.sram_waddr), 64'd0);
        check("async_rst_wdata", 64'(bus.sram_wdata), 64'd0);
        check("async_rst_layer_done", 64'(layer_done), 64'd0);
        check("async_rst_overflow", 64'(overflow), 64'd0);
        repeat (2) tick();
        reset_n    = 1'b1;
        ready_mode = 0;
        repeat (5) tick();
        ld0 = ld_cnt;
        start_layer();
        vals.delete();
        for (int i = 0; i < 4; i++) vals.push_back(rand_val());
        expect_layer(vals);
        foreach (vals[i]) send(vals[i]);
        en = 1'b0;
        wait_done(ld0, "post_reset");

        // Randomized layers: random length, gaps, ready pattern and values
        ready_mode = 2;
        for (int l = 0; l < 25; l++) begin
            if ($urandom % 2 == 1) send(rand_val());
            ld0 = ld_cnt;
            start_layer();
            n = int'($urandom_range(0, 11));
            vals.delete();
            for (int i = 0; i < n; i++) vals.push_back(rand_val());
            expect_layer(vals);
            foreach (vals[i]) begin
                if ($urandom % 3 == 0) tick();
                send(vals[i]);
            end
            if (n < 4 * NUM_WORDS) begin
                en = 1'b0;
                wait_done(ld0, "rand_layer");
            end else begin
                wait_done(ld0, "rand_layer");
                en = 1'b0;
            end
            check("rand_no_overflow", 64'(overflow), 64'd0);
        end

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
